alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - Datapath ALU of the 8-bit microprocessor; sits between the register-file read ports and the writeback mux.
// - Computes AND/ADD/XOR/SUB of two operands combinationally, driving Result and Zero to the datapath in the same cycle.
// - Also latches a 4-bit status word (N,V,C,Z) on each clock edge for the branch/control logic.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; all examples below use 8.
// PORTS
// - CLK       in   1      single clock, rising-edge.
// - Reset     in   1      synchronous, active-high.
// - ALUOp     in   2      operation select.
// - ALUSrcA   in   WIDTH  operand A (minuend for SUB).
// - ALUSrcB   in   WIDTH  operand B (subtrahend for SUB).
// - Result    out  WIDTH  combinational result.
// - Zero      out  1      combinational, 1 when Result == 0.
// - Carry     out  1      combinational carry-out / no-borrow.
// - Negative  out  1      combinational, Result[WIDTH-1].
// - Overflow  out  1      combinational two's-complement overflow.
// - StatusQ   out  4      registered {Negative,Overflow,Carry,Zero}.
// BEHAVIOUR
// - ALUOp decode: 2'b00 AND (A & B); 2'b01 ADD (A + B); 2'b10 XOR (A ^ B); 2'b11 SUB (A - B).
// - ADD/SUB are modulo 2^WIDTH: the result wraps, no saturation.
// - Result, Zero, Carry, Negative, Overflow: purely combinational from ALUOp/ALUSrcA/ALUSrcB.
//   - Zero-latency; independent of CLK and Reset.
// - Carry:
//   - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
//   - SUB: 1 when A >= B unsigned (no borrow); implement as A + ~B + 1 and take the carry-out.
//   - AND/XOR: 0.
// - Overflow:
//   - ADD: A[msb]==B[msb] && Result[msb]!=A[msb].
//   - SUB: A[msb]!=B[msb] && Result[msb]!=A[msb].
//   - AND/XOR: 0.
// - StatusQ:
//   - At each rising CLK, loads {Negative,Overflow,Carry,Zero}; one-cycle latency.
//   - Reset==1 at a rising edge: StatusQ <= 4'b0000. Reset has priority over the update.
//   - Reset has no effect on the combinational outputs.
// - X/unknown ALUOp: Result = 0, flags from that 0 (Zero=1). Default branch, no latch inferred.
// - Operand or op changes mid-cycle: only the value present at the edge is captured in StatusQ.
// STRUCTURE
// - Shared package (cpu_pkg): typedef enum logic [1:0] alu_op_t {ALU_AND=0, ALU_ADD=1, ALU_XOR=2, ALU_SUB=3}; WIDTH default constant.
// - One natural sub-module: alu_addsub.
//   - WIDTH-bit adder with invert-B/carry-in for SUB.
//   - Outputs sum, carry, overflow.
// - Top level: op mux (always_comb unique case), flag logic, and the StatusQ always_ff.
// TESTING
// - A=0x11, B=0x11: AND->0x11 Z=0; ADD->0x22 Z=0; XOR->0x00 Z=1; SUB->0x00 Z=1 C=1.
// - A=0xF0, B=0x0F: AND->0x00 Z=1; ADD->0xFF N=1 C=0; XOR->0xFF; SUB->0xE1 C=1 V=0.
// - A=0xAA, B=0x55: AND->0x00 Z=1; ADD->0xFF; XOR->0xFF; SUB->0x55 C=1 V=1.
// - Wrap/overflow:
//   - ADD 0xFF+0x01 -> 0x00 Z=1 C=1 V=0.
//   - ADD 0x7F+0x01 -> 0x80 N=1 V=1.
//   - SUB 0x00-0x01 -> 0xFF C=0 N=1.
// - StatusQ timing:
//   - Hold Reset 2 cycles -> StatusQ=0000.
//   - Release Reset, apply SUB 0x11-0x11 -> StatusQ=4'b0011 after the next edge, not before.
// - Reset mid-operation: assert Reset while ADD 0x7F+0x01 is applied.
//   - StatusQ -> 0000 at the edge.
//   - Result stays 0x80.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit microprocessor datapath.
// Holds the ALU operation encoding and the default datapath width.
package cpu_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_ADD = 2'd1,
        ALU_XOR = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_t;

    // Packs the status word in the order the branch logic expects: {N,V,C,Z}.
    function automatic logic [3:0] pack_status(input logic n, input logic v,
                                               input logic c, input logic z);
        return {n, v, c, z};
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: computes a + b, or a + ~b + 1 when sub is set.
// Carry-out doubles as the no-borrow flag for subtraction.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   wide_sum;

    assign b_eff    = sub ? ~b : b;
    assign wide_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum      = wide_sum[WIDTH-1:0];
    assign carry    = wide_sum[WIDTH];

    // Operands of equal sign (after inversion) producing a result of the other sign.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Datapath ALU: combinational AND/ADD/XOR/SUB with flags, plus a registered
// {N,V,C,Z} status word for the branch/control logic.
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       ALUOp,
    input  logic [WIDTH-1:0] ALUSrcA,
    input  logic [WIDTH-1:0] ALUSrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow,
    output logic [3:0]       StatusQ
);

    alu_op_t          op;
    logic             is_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;

    assign op     = alu_op_t'(ALUOp);
    assign is_sub = (op == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (ALUSrcA),
        .b        (ALUSrcB),
        .sub      (is_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    // An unknown op falls to the default: result 0, arithmetic flags clear.
    always_comb begin
        Result   = '0;
        Carry    = 1'b0;
        Overflow = 1'b0;
        unique case (op)
            ALU_AND: Result = ALUSrcA & ALUSrcB;
            ALU_XOR: Result = ALUSrcA ^ ALUSrcB;
            ALU_ADD, ALU_SUB: begin
                Result   = as_sum;
                Carry    = as_carry;
                Overflow = as_overflow;
            end
            default: begin
                Result   = '0;
                Carry    = 1'b0;
                Overflow = 1'b0;
            end
        endcase
    end

    assign Zero     = (Result == '0);
    assign Negative = Result[WIDTH-1];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            StatusQ <= 4'b0000;
        end else begin
            StatusQ <= pack_status(Negative, Overflow, Carry, Zero);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: combinational results/flags per vector,
// the registered status word one edge later, and reset timing sequences.
module tb_alu;
    import cpu_pkg::*;

    localparam int W = 8;

    // clock/reset
    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   aluop;
    logic [W-1:0] srca, srcb;
    logic [W-1:0] result;
    logic         zero, carry, negative, overflow;
    logic [3:0]   statusq;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .CLK      (clk),
        .Reset    (reset),
        .ALUOp    (aluop),
        .ALUSrcA  (srca),
        .ALUSrcB  (srcb),
        .Result   (result),
        .Zero     (zero),
        .Carry    (carry),
        .Negative (negative),
        .Overflow (overflow),
        .StatusQ  (statusq)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         n;
        logic         v;
    } vec_t;

    vec_t vecs[$];
    logic [11:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: change inputs away from the rising edge
    task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        aluop = op;
        srca  = a;
        srcb  = b;
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] res, input logic z, input logic c,
                                input logic n, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.res = res;
        t.z = z; t.c = c; t.n = n; t.v = v;
        return t;
    endfunction

    initial begin
        //                op       a      b      res    z     c     n     v
        vecs.push_back(mk(ALU_AND, 8'h11, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_ADD, 8'h11, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_XOR, 8'h11, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_SUB, 8'h11, 8'h11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_ADD, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_XOR, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_SUB, 8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_AND, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_ADD, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_SUB, 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(ALU_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(ALU_SUB, 8'h01, 8'h80, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(ALU_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(ALU_AND, 8'hFF, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0));

        reset = 1'b1;
        aluop = ALU_AND;
        srca  = '0;
        srcb  = '0;

        // Reset held for two edges clears the status word.
        repeat (2) @(posedge clk);
        #1;
        check("reset_statusq", {12'h0, statusq}, 16'h0000);

        // SUB 0x11-0x11 after release: status appears only after the next edge.
        @(negedge clk);
        reset = 1'b0;
        aluop = ALU_SUB;
        srca  = 8'h11;
        srcb  = 8'h11;
        #1;
        check("post_reset_result", {8'h0, result}, 16'h0000);
        check("post_reset_before_edge", {12'h0, statusq}, 16'h0000);
        @(posedge clk);
        #1;
        check("post_reset_after_edge", {12'h0, statusq}, 16'h0003);

        // Table: combinational outputs, then registered status one edge later.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_comb{res,z,c,n,v}", i),
                  {4'h0, result, zero, carry, negative, overflow},
                  {4'h0, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].n, vecs[i].v});
            exp_q.push_back({8'h0, vecs[i].n, vecs[i].v, vecs[i].c, vecs[i].z});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_statusq", i), {12'h0, statusq}, {4'h0, exp_q.pop_front()});
        end

        // Reset asserted while ADD 0x7F+0x01 is applied.
        drive(ALU_ADD, 8'h7F, 8'h01);
        @(posedge clk);
        #1;
        check("midop_status_loaded", {12'h0, statusq}, 16'h000C);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midop_result_in_reset", {8'h0, result}, 16'h0080);
        check("midop_flags_in_reset", {12'h0, negative, overflow, carry, zero}, 16'h000C);
        check("midop_status_before_edge", {12'h0, statusq}, 16'h000C);
        @(posedge clk);
        #1;
        check("midop_status_cleared", {12'h0, statusq}, 16'h0000);
        check("midop_result_after_edge", {8'h0, result}, 16'h0080);

        // Inputs changing mid-cycle: only the value present at the edge is captured.
        @(negedge clk);
        reset = 1'b0;
        aluop = ALU_ADD; srca = 8'hFF; srcb = 8'h01;
        #2;
        aluop = ALU_XOR; srca = 8'hAA; srcb = 8'h55;
        @(posedge clk);
        #1;
        check("midcycle_change_statusq", {12'h0, statusq}, 16'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
